// File: rtl/ring_phase_tracker.sv
// ring_phase_tracker
// Watches a one-hot ring counter. Each cycle it checks that the ring moved
// by exactly one position to the left, turns the set bit into a binary phase
// index, declares lock after LOCK_CNT good steps in a row, and raises a sticky
// error if the ring is corrupted while locked.
//
// Optional feature macro: RING_REV_CNT_EN
//   defined   : revolution counter (rev_cnt) and revolution pulse (rev_pulse)
//   undefined : rev_cnt and rev_pulse are tied to 0 and have no flops
//
// Sample classes (exactly one applies to each ring_in sample):
//   good : ring_in one-hot, prev one-hot, ring_in == rotl(prev)
//   hold : ring_in one-hot and equal to prev (upstream ring stalled or in reset)
//   seed : ring_in one-hot, prev not one-hot (first sample after reset)
//   bad  : anything else (zero, multi-hot, or a one-hot value that jumped)
// Hold and seed leave the FSM and the good-step counter untouched.
module ring_phase_tracker #(
  parameter int WIDTH    = 4,
  parameter int LOCK_CNT = 3,
  parameter int REV_W    = 8
) (
  input  logic                       clk,
  input  logic                       rstn,
  input  logic [WIDTH-1:0]           ring_in,
  input  logic                       clr,
  output logic [$clog2(WIDTH)-1:0]   phase,
  output logic                       phase_vld,
  output logic                       locked,
  output logic                       err,
  output logic [REV_W-1:0]           rev_cnt,
  output logic                       rev_pulse
);

  localparam int PW = $clog2(WIDTH);

  typedef enum logic [1:0] {
    HUNT   = 2'd0,
    LOCKED = 2'd1,
    ERROR  = 2'd2
  } state_t;

  typedef enum logic [1:0] {
    CLS_GOOD = 2'd0,
    CLS_HOLD = 2'd1,
    CLS_SEED = 2'd2,
    CLS_BAD  = 2'd3
  } cls_t;

  // FSM state is kept in a named register so checkers can bind to it directly.
  state_t           state_q;
  state_t           state_d;
  logic [3:0]       good_cnt_q;
  logic [3:0]       good_cnt_d;
  logic [WIDTH-1:0] prev;
  logic [WIDTH-1:0] rotl_prev;
  logic             in_oh;
  logic             prev_oh;
  cls_t             cls;
  logic             err_set;
  logic [PW-1:0]    phase_idx;

  assign rotl_prev = {prev[WIDTH-2:0], prev[WIDTH-1]};
  assign in_oh     = $onehot(ring_in);
  assign prev_oh   = $onehot(prev);

  // Classify the current sample against the previous one.
  always_comb begin
    cls = CLS_BAD;
    if (in_oh && prev_oh && (ring_in == rotl_prev)) begin
      cls = CLS_GOOD;
    end else if (in_oh && (ring_in == prev)) begin
      cls = CLS_HOLD;
    end else if (in_oh && !prev_oh) begin
      cls = CLS_SEED;
    end
  end

  // Encode the set bit of ring_in; only used when ring_in is one-hot.
  always_comb begin
    phase_idx = '0;
    for (int i = 0; i < WIDTH; i++) begin
      if (ring_in[i]) begin
        phase_idx = PW'(i);
      end
    end
  end

  // Next-state logic: lock after LOCK_CNT good steps, error exits through a
  // single ERROR cycle whose sample is ignored.
  always_comb begin
    state_d    = state_q;
    good_cnt_d = good_cnt_q;
    err_set    = 1'b0;
    case (state_q)
      HUNT: begin
        if (cls == CLS_GOOD) begin
          if (good_cnt_q + 4'd1 == 4'(LOCK_CNT)) begin
            state_d    = LOCKED;
            good_cnt_d = '0;
          end else begin
            good_cnt_d = good_cnt_q + 4'd1;
          end
        end else if (cls == CLS_BAD) begin
          good_cnt_d = '0;
        end
      end
      LOCKED: begin
        if (cls == CLS_BAD) begin
          state_d = ERROR;
          err_set = 1'b1;
        end
      end
      ERROR: begin
        state_d    = HUNT;
        good_cnt_d = '0;
      end
      default: begin
        state_d    = HUNT;
        good_cnt_d = '0;
      end
    endcase
  end

  // State and good-step counter registers.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q    <= HUNT;
      good_cnt_q <= '0;
    end else begin
      state_q    <= state_d;
      good_cnt_q <= good_cnt_d;
    end
  end

  // Previous sample, the reference for the rotation check.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      prev <= '0;
    end else begin
      prev <= ring_in;
    end
  end

  // Phase follows every one-hot sample and holds across invalid ones.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      phase     <= '0;
      phase_vld <= 1'b0;
    end else begin
      phase_vld <= in_oh;
      if (in_oh) begin
        phase <= phase_idx;
      end
    end
  end

  // Sticky error: a new error event wins over a simultaneous clear.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      err <= 1'b0;
    end else if (err_set) begin
      err <= 1'b1;
    end else if (clr) begin
      err <= 1'b0;
    end
  end

  assign locked = (state_q == LOCKED);

`ifdef RING_REV_CNT_EN
  logic rev_event;

  // A revolution is the MSB-to-bit0 wrap seen as a good step while locked.
  assign rev_event = (state_q == LOCKED) && (cls == CLS_GOOD) && ring_in[0];

  // Revolution counter and pulse; clear wins over a simultaneous increment
  // but the pulse still fires.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      rev_cnt   <= '0;
      rev_pulse <= 1'b0;
    end else begin
      rev_pulse <= rev_event;
      if (clr) begin
        rev_cnt <= '0;
      end else if (rev_event) begin
        rev_cnt <= rev_cnt + 1'b1;
      end
    end
  end
`else
  assign rev_cnt   = '0;
  assign rev_pulse = 1'b0;
`endif

endmodule

// File: tb/tb_ring_phase_tracker.sv
// Testbench for ring_phase_tracker: directed scenarios followed by random
// ring traffic, all compared against a behavioural model working on phase
// indices (modulo arithmetic) rather than bit rotations.
module tb_ring_phase_tracker;

  localparam int WIDTH    = 4;
  localparam int LOCK_CNT = 3;
  localparam int REV_W    = 8;
  localparam int PW       = $clog2(WIDTH);

  localparam int M_HUNT   = 0;
  localparam int M_LOCKED = 1;
  localparam int M_ERROR  = 2;

  logic              clk = 1'b0;
  logic              rstn = 1'b1;
  logic              clr = 1'b0;
  logic [WIDTH-1:0]  ring_in = '0;
  logic [PW-1:0]     phase;
  logic              phase_vld;
  logic              locked;
  logic              err;
  logic [REV_W-1:0]  rev_cnt;
  logic              rev_pulse;

  int checks   = 0;
  int failures = 0;
  int cycle    = 0;

  // Reference model state
  logic [WIDTH-1:0] m_prev;
  int               m_state;
  int               m_streak;
  int               m_phase;
  bit               m_vld;
  bit               m_err;
  int               m_rev;
  bit               m_pulse;

  logic [WIDTH-1:0] cur;

  ring_phase_tracker #(
    .WIDTH   (WIDTH),
    .LOCK_CNT(LOCK_CNT),
    .REV_W   (REV_W)
  ) dut (
    .clk      (clk),
    .rstn     (rstn),
    .ring_in  (ring_in),
    .clr      (clr),
    .phase    (phase),
    .phase_vld(phase_vld),
    .locked   (locked),
    .err      (err),
    .rev_cnt  (rev_cnt),
    .rev_pulse(rev_pulse)
  );

  // Clock
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s cycle=%0d got=%0h expected=%0h", tag, cycle, obs, exp);
    end
  endtask

  function automatic bit is_oh(input logic [WIDTH-1:0] v);
    return $countones(v) == 1;
  endfunction

  function automatic int idx_of(input logic [WIDTH-1:0] v);
    for (int i = 0; i < WIDTH; i++) begin
      if (v[i]) return i;
    end
    return 0;
  endfunction

  // Next ring value: one position further round the ring.
  function automatic logic [WIDTH-1:0] next_of(input logic [WIDTH-1:0] v);
    logic [WIDTH-1:0] r;
    r = '0;
    if (is_oh(v)) r[(idx_of(v) + 1) % WIDTH] = 1'b1;
    else          r[0] = 1'b1;
    return r;
  endfunction

  task automatic model_reset();
    m_prev   = '0;
    m_state  = M_HUNT;
    m_streak = 0;
    m_phase  = 0;
    m_vld    = 0;
    m_err    = 0;
    m_rev    = 0;
    m_pulse  = 0;
  endtask

  task automatic model_step(input logic [WIDTH-1:0] v, input logic c);
    bit in_oh, pr_oh, good, neutral, bad, err_ev, rev_ev;
    in_oh   = is_oh(v);
    pr_oh   = is_oh(m_prev);
    good    = in_oh && pr_oh && (idx_of(v) == (idx_of(m_prev) + 1) % WIDTH);
    neutral = !good && in_oh && ((v == m_prev) || !pr_oh);
    bad     = !good && !neutral;
    err_ev  = 0;
    rev_ev  = 0;
    if (m_state == M_HUNT) begin
      if (good) begin
        m_streak++;
        if (m_streak == LOCK_CNT) begin
          m_state  = M_LOCKED;
          m_streak = 0;
        end
      end else if (bad) begin
        m_streak = 0;
      end
    end else if (m_state == M_LOCKED) begin
      if (bad) begin
        err_ev  = 1;
        m_state = M_ERROR;
      end else if (good && idx_of(v) == 0) begin
        rev_ev = 1;
      end
    end else begin
      m_state  = M_HUNT;
      m_streak = 0;
    end
    if (err_ev)  m_err = 1;
    else if (c)  m_err = 0;
`ifdef RING_REV_CNT_EN
    m_pulse = rev_ev;
    if (c)           m_rev = 0;
    else if (rev_ev) m_rev = (m_rev + 1) % (1 << REV_W);
`else
    m_pulse = 0;
    m_rev   = 0;
`endif
    m_vld = in_oh;
    if (in_oh) m_phase = idx_of(v);
    m_prev = v;
  endtask

  task automatic check_outputs(input string pfx);
    check({pfx, "_phase"},     32'(phase),     32'(m_phase));
    check({pfx, "_phase_vld"}, 32'(phase_vld), 32'(m_vld));
    check({pfx, "_locked"},    32'(locked),    32'(m_state == M_LOCKED));
    check({pfx, "_err"},       32'(err),       32'(m_err));
    check({pfx, "_rev_cnt"},   32'(rev_cnt),   32'(m_rev));
    check({pfx, "_rev_pulse"}, 32'(rev_pulse), 32'(m_pulse));
  endtask

  // Driver: apply inputs at a falling edge, let the rising edge sample them,
  // then compare at the following falling edge.
  task automatic drive(input logic [WIDTH-1:0] v, input logic c, input string pfx);
    ring_in = v;
    clr     = c;
    @(posedge clk);
    model_step(v, c);
    cycle++;
    @(negedge clk);
    check_outputs(pfx);
    clr = 1'b0;
    cur = v;
  endtask

  // Asynchronous reset: outputs must clear before any clock edge.
  task automatic apply_reset();
    rstn = 1'b0;
    model_reset();
    #1;
    check_outputs("rst_async");
    check("rst_locked_zero", 32'(locked), 32'd0);
    check("rst_rev_zero",    32'(rev_cnt), 32'd0);
    @(negedge clk);
    @(negedge clk);
    rstn = 1'b1;
    cur  = '0;
  endtask

  task automatic lock_up(input string pfx);
    drive(4'b0001, 1'b0, pfx);
    drive(4'b0010, 1'b0, pfx);
    drive(4'b0100, 1'b0, pfx);
    drive(4'b1000, 1'b0, pfx);
  endtask

  initial begin
    int r;
    logic [WIDTH-1:0] v;
    logic c;
    model_reset();
    cur = '0;
    #2;
    apply_reset();

    // Basic lock and first revolution
    lock_up("lock");
    check("tp_locked_edge4", 32'(locked), 32'd1);
    check("tp_phase_edge4",  32'(phase),  32'd3);
    check("tp_rev_edge4",    32'(rev_cnt), 32'd0);
    drive(4'b0001, 1'b0, "rev1");
`ifdef RING_REV_CNT_EN
    check("tp_rev_pulse_edge5", 32'(rev_pulse), 32'd1);
    check("tp_rev_cnt_edge5",   32'(rev_cnt),   32'd1);
`endif
    check("tp_phase_edge5", 32'(phase), 32'd0);
    drive(4'b0010, 1'b0, "rev1_after");
    check("tp_rev_pulse_one_cycle", 32'(rev_pulse), 32'd0);

    // Hold then rotate: lock on the third good step
    @(negedge clk);
    #1;
    apply_reset();
    for (int i = 0; i < 5; i++) begin
      drive(4'b0001, 1'b0, "hold");
      check("tp_hold_not_locked", 32'(locked), 32'd0);
    end
    drive(4'b0010, 1'b0, "hold_rot");
    drive(4'b0100, 1'b0, "hold_rot");
    check("tp_hold_not_yet", 32'(locked), 32'd0);
    drive(4'b1000, 1'b0, "hold_rot");
    check("tp_hold_lock3", 32'(locked), 32'd1);

    // Multi-hot while locked at phase 1
    drive(4'b0001, 1'b0, "mh");
    drive(4'b0010, 1'b0, "mh");
    drive(4'b0110, 1'b0, "mh_bad");
    check("tp_mh_err",    32'(err),       32'd1);
    check("tp_mh_locked", 32'(locked),    32'd0);
    check("tp_mh_vld",    32'(phase_vld), 32'd0);
    check("tp_mh_phase",  32'(phase),     32'd1);
    drive(4'b0100, 1'b0, "mh_errcyc");
    drive(4'b1000, 1'b0, "mh_relock");
    drive(4'b0001, 1'b0, "mh_relock");
    check("tp_mh_not_yet", 32'(locked), 32'd0);
    drive(4'b0010, 1'b0, "mh_relock");
    check("tp_mh_relocked", 32'(locked), 32'd1);
    check("tp_mh_err_sticky", 32'(err), 32'd1);
    drive(4'b0100, 1'b1, "mh_clr");
    check("tp_mh_err_cleared", 32'(err), 32'd0);

    // Skipped phase while locked, then a bad sample in HUNT
    drive(4'b1000, 1'b0, "skip");
    drive(4'b0001, 1'b0, "skip");
    drive(4'b0010, 1'b0, "skip");
    drive(4'b1000, 1'b0, "skip_bad");
    check("tp_skip_err", 32'(err), 32'd1);
    check("tp_skip_unlocked", 32'(locked), 32'd0);
    drive(4'b0001, 1'b0, "skip_errcyc");
    drive(4'b0010, 1'b1, "skip_clr");
    drive(4'b0000, 1'b0, "hunt_bad");
    check("tp_hunt_bad_no_err", 32'(err), 32'd0);

    // Error and clear on the same edge: error wins
    lock_up("errclr");
    lock_up("errclr");
    drive(4'b0100, 1'b1, "errclr_hit");
    check("tp_err_beats_clr", 32'(err), 32'd1);

    // Full 256-revolution wrap, then clear on a revolution edge
    @(negedge clk);
    #1;
    apply_reset();
    lock_up("wrap");
    for (int i = 0; i < 256 * WIDTH; i++) begin
      drive(next_of(cur), 1'b0, "wrap");
    end
    check("tp_wrap_zero", 32'(rev_cnt), 32'd0);
    drive(4'b0001, 1'b0, "wrap_more");
    drive(4'b0010, 1'b0, "wrap_more");
    drive(4'b0100, 1'b0, "wrap_more");
    drive(4'b1000, 1'b0, "wrap_more");
    drive(4'b0001, 1'b1, "clr_rev");
    check("tp_clr_rev_cnt", 32'(rev_cnt), 32'd0);
`ifdef RING_REV_CNT_EN
    check("tp_clr_rev_pulse", 32'(rev_pulse), 32'd1);
`else
    check("tp_clr_rev_pulse", 32'(rev_pulse), 32'd0);
`endif

    // Random traffic
    for (int i = 0; i < 600; i++) begin
      r = $urandom_range(0, 99);
      if (r < 70)      v = next_of(cur);
      else if (r < 80) v = cur;
      else if (r < 90) v = WIDTH'($urandom_range(0, (1 << WIDTH) - 1));
      else begin
        v = '0;
        v[$urandom_range(0, WIDTH - 1)] = 1'b1;
      end
      c = ($urandom_range(0, 19) == 0);
      drive(v, c, "rand");
    end

    // Asynchronous reset while locked with five revolutions counted
    @(negedge clk);
    #1;
    apply_reset();
    lock_up("async");
    for (int i = 0; i < 5 * WIDTH; i++) begin
      drive(next_of(cur), 1'b0, "async");
    end
    check("tp_async_locked", 32'(locked), 32'd1);
`ifdef RING_REV_CNT_EN
    check("tp_async_rev5", 32'(rev_cnt), 32'd5);
`endif
    #1;
    apply_reset();
    check("tp_async_phase", 32'(phase), 32'd0);
    drive(4'b0100, 1'b0, "post_rst_seed");
    check("tp_post_rst_seed_unlocked", 32'(locked), 32'd0);
    drive(4'b1000, 1'b0, "post_rst");
    drive(4'b0001, 1'b0, "post_rst");
    drive(4'b0010, 1'b0, "post_rst");
    check("tp_post_rst_locked", 32'(locked), 32'd1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
